// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator behind a 2-entry skid buffer (optional IMM_GEN_ILLEGAL_EN adds illegal_o)
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             imm_valid_o,
    input  logic             imm_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       imm_fmt_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);
    logic [6:0]      op;
    logic [2:0]      fmt;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            s;
    assign op = instr_i[6:0];
    assign s  = instr_i[31];
    // decode the format and build the 32-bit immediate, then sign-extend from bit 31
    always_comb begin
        fmt = (op == 7'h13 || op == 7'h03 || op == 7'h67 || (XLEN == 64 && op == 7'h1B)) ? 3'd1 :
              (op == 7'h23) ? 3'd2 :
              (op == 7'h63) ? 3'd3 :
              (op == 7'h37 || op == 7'h17) ? 3'd4 :
              (op == 7'h6F) ? 3'd5 : 3'd0;
        imm32 = (fmt == 3'd1) ? {{20{s}}, instr_i[31:20]} :
                (fmt == 3'd2) ? {{20{s}}, instr_i[31:25], instr_i[11:7]} :
                (fmt == 3'd3) ? {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                (fmt == 3'd4) ? {instr_i[31:12], 12'b0} :
                (fmt == 3'd5) ? {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} : 32'd0;
        imm = XLEN'($signed(imm32));
    end
`ifdef IMM_GEN_ILLEGAL_EN
    localparam int PW = XLEN + TAG_W + 4;
    logic ill;
    assign ill = (fmt == 3'd0) && !(op == 7'h33 || (XLEN == 64 && op == 7'h3B));
    logic [PW-1:0] in_pl, out_pl, skid_pl;
    assign in_pl = {ill, fmt, imm, tag_i};
    assign {illegal_o, imm_fmt_o, imm_o, tag_o} = out_pl;
`else
    localparam int PW = XLEN + TAG_W + 3;
    logic [PW-1:0] in_pl, out_pl, skid_pl;
    assign in_pl = {fmt, imm, tag_i};
    assign {imm_fmt_o, imm_o, tag_o} = out_pl;
    assign illegal_o = 1'b0;
`endif
    logic out_valid, skid_valid, accept;
    assign imm_valid_o   = out_valid;
    assign instr_ready_o = !skid_valid;
    assign accept        = instr_valid_i && instr_ready_o;
    // output register refills from skid first, else from the input; a stalled output diverts input into skid
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_pl     <= '0;
            skid_pl    <= '0;
        end else if (!out_valid || imm_ready_i) begin
            if (skid_valid) begin
                out_pl     <= skid_pl;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_pl <= in_pl;
            end
        end else if (accept) begin
            skid_pl    <= in_pl;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the RV32I/RV64I decode stage. It accepts an instruction word over a valid/ready handshake and extracts and sign-extends the immediate for every base format (I, S, B, U, J) to XLEN bits. It reports the format code and passes a tag through. Output is registered behind a 2-entry skid buffer so the execute stage can stall without a combinational ready path.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 8, width of the pass-through tag (e.g. PC index or ROB id)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
instr_valid_i  input  1  upstream has a valid instruction
instr_ready_o  output  1  block can accept this cycle
instr_i  input  32  instruction word
tag_i  input  TAG_W  sideband, returned unchanged with result
imm_valid_o  output  1  result valid
imm_ready_i  input  1  downstream accepts result
imm_o  output  XLEN  sign-extended immediate
imm_fmt_o  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
tag_o  output  TAG_W  tag of the instruction at the output
illegal_o  output  1  unrecognised opcode (see Optional Feature)

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high.
- Reset: imm_valid_o=0, imm_o=0, imm_fmt_o=0, tag_o=0, illegal_o=0, skid buffer empty, instr_ready_o=1 in the first cycle after reset.
- Reset mid-operation discards both buffer entries. Any instruction presented during the reset cycle is dropped.
- Accept: instr_valid_i & instr_ready_o. Produce: imm_valid_o & imm_ready_i.
- Latency 1 cycle: an instruction accepted at edge N appears at the output after edge N if the output is empty or draining.
- Skid buffer: output register plus one skid register.
  - instr_ready_o is a registered signal, equal to !skid_full.
  - Output valid and imm_ready_i=0 while a new word is accepted: the new word goes to skid.
  - Output valid and imm_ready_i=1 with skid full: skid moves to output, and ready rises on the next cycle.
  - Simultaneous accept and produce with skid empty: the new word loads directly into output.
- Ordering is strict FIFO. The output holds stable while imm_valid_o=1 and imm_ready_i=0. No word is lost or duplicated.
- Decode, opcode = instr_i[6:0]:
  - 0x13, 0x03, 0x67: I type, imm = sext(instr[31:20]).
  - 0x23: S type, imm = sext({instr[31:25], instr[11:7]}).
  - 0x63: B type, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0x37, 0x17: U type, imm = sext({instr[31:12], 12'b0}). The value is the upper bits shifted left, not zero-extended.
  - 0x6F: J type, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0x33: NONE, imm=0, legal.
  - XLEN=64 only: 0x1B is I type, 0x3B is NONE legal.
  - All other opcodes: NONE, imm=0, illegal.
- Sign extension always comes from instr[31], to the full XLEN.
- Shift-immediate forms output the raw I field; shamt masking is not done here.
- Decode is combinational on the input side. Only registered values drive outputs.

Optional Feature:
- Macro IMM_GEN_ILLEGAL_EN.
- Defined: illegal_o is registered alongside imm_o and is 1 for any opcode not listed above. It follows the same skid/ordering rules as the data.
- Not defined: illegal_o is tied to 0, no illegal-detect logic is built, and unknown opcodes still decode as NONE/imm=0.

Test Plan:
- XLEN=32, imm_ready_i=1, instr 0xFFF00093 (addi x1,x0,-1), tag 0x11 -> next cycle: imm_o=0xFFFFFFFF, fmt=1, tag_o=0x11.
- Back-to-back, ready high, three instructions:
  - 0xFE112E23 (sw -4) -> imm 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFF8, fmt 3.
  - 0x0010006F (jal +2048) -> imm 0x00000800, fmt 5.
  - Required: one result per cycle, in order.
- Backpressure:
  - Hold imm_ready_i=0 and offer 3 words -> exactly 2 accepted, instr_ready_o=0 from the cycle after the 2nd accept, and the output stays stable.
  - Release ready -> results drain in order and no word is duplicated.
- XLEN=64:
  - 0x123450B7 (lui 0x12345) -> imm 0x0000000012345000, fmt 4.
  - 0x800000B7 -> imm 0xFFFFFFFF80000000.
  - 0x0000001B (addiw 0) -> fmt 1, imm 0.
- Assert reset for one cycle with both buffer entries full -> next cycle imm_valid_o=0, all outputs 0, instr_ready_o=1.
- IMM_GEN_ILLEGAL_EN defined, XLEN=32:
  - 0x0000007F -> illegal_o=1, fmt 0, imm 0.
  - 0x00000033 -> illegal_o=0.
  - With the macro undefined, illegal_o stays 0 throughout.
